// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   ctrlState_e   : controller FSM state encoding
//   CNT_W_DEFAULT : default width of the stall-cycle counter
package pipe_stall_ctrl_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        DWAIT = 2'b01,
        HALT  = 2'b10
    } ctrlState_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc=1, sticks at all-ones.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, clears count
//   inc   : increment request for this cycle
//   count : current count (registered)
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline. Resolves, each cycle and
// with fixed priority (halt > freeze > flush > load-use > fetch stall),
// the pipeline register write enables and NOP-insert controls.
//   clk, rst_n        : clock and synchronous active-low reset
//   ld_use_haz        : decode needs one bubble behind an EX-stage load
//   br_taken          : EX redirect, younger IF/ID and ID/EX are wrong-path
//   dmem_stall/done   : data memory busy / access completing this cycle
//   imem_stall        : fetch not ready
//   halt_req          : halt instruction in WB
//   pc_we..exmem_we   : pipeline register write enables (combinational)
//   ifid_flush, idex_bubble, memwb_bubble : NOP inserts (combinational)
//   halted            : processor halted
//   stall_cnt         : saturating count of cycles with pc_we=0
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_use_haz,
    input  logic             br_taken,
    input  logic             dmem_stall,
    input  logic             dmem_done,
    input  logic             imem_stall,
    input  logic             halt_req,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             memwb_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    ctrlState_e stateQ, stateD;
    logic       flushPendQ, flushPendD;
    logic       freeze;
    logic       stallInc;

    // State and pending-flush registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ     <= RUN;
            flushPendQ <= 1'b0;
        end else begin
            stateQ     <= stateD;
            flushPendQ <= flushPendD;
        end
    end

    // Priority resolution and next-state logic
    always_comb begin
        stateD       = stateQ;
        flushPendD   = flushPendQ;
        freeze       = 1'b0;
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        idex_we      = 1'b0;
        exmem_we     = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        memwb_bubble = 1'b0;
        halted       = 1'b0;

        if (!rst_n) begin
            stateD     = RUN;
            flushPendD = 1'b0;
        end else if (stateQ == HALT) begin
            halted     = 1'b1;
            flushPendD = 1'b0;
        end else begin
            // A completing access unfreezes the cycle even if stall is still up
            freeze = (stateQ == DWAIT) ? !dmem_done : (dmem_stall && !dmem_done);

            if (freeze) begin
                memwb_bubble = 1'b1;
                // A redirect seen while frozen is replayed on the first live cycle
                if (br_taken) begin
                    flushPendD = 1'b1;
                end
            end else if (br_taken || flushPendQ) begin
                pc_we       = 1'b1;
                ifid_we     = 1'b1;
                idex_we     = 1'b1;
                exmem_we    = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                flushPendD  = 1'b0;
            end else if (ld_use_haz) begin
                idex_we     = 1'b1;
                exmem_we    = 1'b1;
                idex_bubble = 1'b1;
            end else if (imem_stall) begin
                ifid_we    = 1'b1;
                idex_we    = 1'b1;
                exmem_we   = 1'b1;
                ifid_flush = 1'b1;
            end else begin
                pc_we    = 1'b1;
                ifid_we  = 1'b1;
                idex_we  = 1'b1;
                exmem_we = 1'b1;
            end

            if (halt_req) begin
                stateD = HALT;
            end else if (stateQ == DWAIT) begin
                stateD = dmem_done ? RUN : DWAIT;
            end else begin
                stateD = (dmem_stall && !dmem_done) ? DWAIT : RUN;
            end
        end
    end

    // Count lost PC-advance cycles; halt and reset cycles are not stalls
    assign stallInc = rst_n && (stateQ != HALT) && !pc_we;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stallCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stallInc),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl. Two instances share stimulus: the
// default-width one and a 4-bit-counter one for the saturation behaviour.
module tb_pipe_stall_ctrl;

    // Control vector order: pc, ifid, idex, exmem, ifid_flush, idex_bubble, memwb_bubble, halted
    localparam logic [7:0] V_NORM = 8'b1111_0000;
    localparam logic [7:0] V_FRZ  = 8'b0000_0010;
    localparam logic [7:0] V_FLU  = 8'b1111_1100;
    localparam logic [7:0] V_LDU  = 8'b0011_0100;
    localparam logic [7:0] V_FET  = 8'b0111_1000;
    localparam logic [7:0] V_HLT  = 8'b0000_0001;
    localparam logic [7:0] V_RST  = 8'b0000_0000;

    typedef struct {
        logic [7:0]  ctrl;
        logic [15:0] c16;
        logic [3:0]  c4;
        string       tag;
    } expEntry_t;

    logic clk;
    logic rst_n, ld_use_haz, br_taken, dmem_stall, dmem_done, imem_stall, halt_req;
    logic pcWeA, ifidWeA, idexWeA, exmemWeA, ifidFlushA, idexBubA, memwbBubA, haltedA;
    logic pcWeB, ifidWeB, idexWeB, exmemWeB, ifidFlushB, idexBubB, memwbBubB, haltedB;
    logic [15:0] cntA;
    logic [3:0]  cntB;
    logic [7:0]  ctrlA, ctrlB;

    expEntry_t sbQ[$];
    int errCnt = 0;
    int chkCnt = 0;
    logic [15:0] model16 = '0;
    logic [3:0]  model4  = '0;

    pipe_stall_ctrl u_dut16 (
        .clk(clk), .rst_n(rst_n), .ld_use_haz(ld_use_haz), .br_taken(br_taken),
        .dmem_stall(dmem_stall), .dmem_done(dmem_done), .imem_stall(imem_stall),
        .halt_req(halt_req), .pc_we(pcWeA), .ifid_we(ifidWeA), .idex_we(idexWeA),
        .exmem_we(exmemWeA), .ifid_flush(ifidFlushA), .idex_bubble(idexBubA),
        .memwb_bubble(memwbBubA), .halted(haltedA), .stall_cnt(cntA)
    );

    pipe_stall_ctrl #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .ld_use_haz(ld_use_haz), .br_taken(br_taken),
        .dmem_stall(dmem_stall), .dmem_done(dmem_done), .imem_stall(imem_stall),
        .halt_req(halt_req), .pc_we(pcWeB), .ifid_we(ifidWeB), .idex_we(idexWeB),
        .exmem_we(exmemWeB), .ifid_flush(ifidFlushB), .idex_bubble(idexBubB),
        .memwb_bubble(memwbBubB), .halted(haltedB), .stall_cnt(cntB)
    );

    assign ctrlA = {pcWeA, ifidWeA, idexWeA, exmemWeA, ifidFlushA, idexBubA, memwbBubA, haltedA};
    assign ctrlB = {pcWeB, ifidWeB, idexWeB, exmemWeB, ifidFlushB, idexBubB, memwbBubB, haltedB};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one cycle of inputs, push its expectation, advance the count model
    task automatic step(input logic rn, input logic ld, input logic br, input logic ds,
                        input logic dd, input logic im, input logic hr,
                        input logic [7:0] exp, input string tag);
        expEntry_t e;
        @(negedge clk);
        rst_n = rn; ld_use_haz = ld; br_taken = br;
        dmem_stall = ds; dmem_done = dd; imem_stall = im; halt_req = hr;
        e.ctrl = exp; e.c16 = model16; e.c4 = model4; e.tag = tag;
        sbQ.push_back(e);
        if (!rn) begin
            model16 = '0;
            model4  = '0;
        end else if (!exp[7] && !exp[0]) begin
            if (model16 != 16'hFFFF) model16 = model16 + 16'd1;
            if (model4 != 4'hF)      model4  = model4 + 4'd1;
        end
    endtask

    // Monitor: compare outputs mid-low-phase, after the inputs settle
    initial begin
        expEntry_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                checkVal({e.tag, ".ctrl16"}, 32'(ctrlA), 32'(e.ctrl));
                checkVal({e.tag, ".ctrl4"},  32'(ctrlB), 32'(e.ctrl));
                checkVal({e.tag, ".cnt16"},  32'(cntA),  32'(e.c16));
                checkVal({e.tag, ".cnt4"},   32'(cntB),  32'(e.c4));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ld_use_haz = 1'b0; br_taken = 1'b0; dmem_stall = 1'b0;
        dmem_done = 1'b0; imem_stall = 1'b0; halt_req = 1'b0;

        //    rn ld br ds dd im hr
        step(0, 0, 0, 0, 0, 0, 0, V_RST,  "reset");
        step(1, 0, 0, 0, 0, 0, 0, V_NORM, "idle");
        // load-use bubble
        step(1, 1, 0, 0, 0, 0, 0, V_LDU,  "ldUse");
        step(1, 0, 0, 0, 0, 0, 0, V_NORM, "ldUseAfter");
        step(1, 0, 0, 0, 0, 0, 0, V_NORM, "ldUseCnt");
        // fetch stall
        step(1, 0, 0, 0, 0, 1, 0, V_FET,  "fetch");
        // branch and load-use together: flush only
        step(1, 1, 1, 0, 0, 0, 0, V_FLU,  "brLd");
        step(1, 0, 0, 0, 0, 0, 0, V_NORM, "brLdAfter");
        // stall and done together in RUN: normal, stays RUN
        step(1, 0, 0, 1, 1, 0, 0, V_NORM, "stallDone");
        step(1, 0, 0, 0, 0, 0, 0, V_NORM, "stallDoneAfter");
        // freeze 3 cycles, branch on cycle 2, hazards on cycle 3 ignored
        step(1, 0, 0, 1, 0, 0, 0, V_FRZ,  "frz1");
        step(1, 0, 1, 1, 0, 0, 0, V_FRZ,  "frz2");
        step(1, 1, 0, 1, 0, 1, 0, V_FRZ,  "frz3");
        step(1, 0, 0, 0, 1, 0, 0, V_FLU,  "frzDone");
        step(1, 0, 0, 0, 0, 0, 0, V_NORM, "frzAfter");
        // DWAIT stays frozen with dmem_stall low until done
        step(1, 0, 0, 1, 0, 0, 0, V_FRZ,  "dw1");
        step(1, 0, 0, 0, 0, 0, 0, V_FRZ,  "dw2");
        step(1, 0, 0, 0, 1, 0, 0, V_NORM, "dwDone");
        // reset mid-DWAIT with a pending flush
        step(1, 0, 0, 1, 0, 0, 0, V_FRZ,  "rstDw1");
        step(1, 0, 1, 1, 0, 0, 0, V_FRZ,  "rstDw2");
        step(0, 0, 0, 1, 0, 0, 0, V_RST,  "rstDw");
        step(1, 0, 0, 0, 0, 0, 0, V_NORM, "rstDwAfter");
        // saturation of the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 0, 0, 1, 0, V_FET, $sformatf("sat%0d", i));
        end
        step(1, 0, 0, 0, 0, 0, 0, V_NORM, "satAfter");
        // halt requested while in DWAIT
        step(1, 0, 0, 1, 0, 0, 0, V_FRZ,  "hltDw");
        step(1, 0, 0, 1, 0, 0, 1, V_FRZ,  "hltReq");
        for (int i = 0; i < 10; i++) begin
            step(1, i[0], i[1], i[2], i[0], 1'b1, 1'b0, V_HLT, $sformatf("halt%0d", i));
        end
        step(0, 0, 0, 0, 0, 0, 0, V_RST,  "hltRst");
        step(1, 0, 0, 0, 0, 0, 0, V_NORM, "hltRstAfter");
        step(1, 0, 0, 0, 0, 1, 0, V_FET,  "postFetch");
        step(1, 0, 0, 0, 0, 0, 0, V_NORM, "final");

        @(negedge clk);
        #5;
        checkVal("sbDrain", 32'(sbQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
